// File: rtl/spi_transmitter_if.sv
// SPI transmitter bus: host-side handshake plus the serial link pins.
// With SPI_TRANSMITTER_READBACK_EN defined, the bus also carries sdi and rx_data.
interface spi_transmitter_if #(
    parameter int bitcount = 16
);
    logic                trigger;
    logic [bitcount-1:0] data;
    logic                ss;
    logic                sclk;
    logic                sdo;
    logic                busy;
    logic                complete;
`ifdef SPI_TRANSMITTER_READBACK_EN
    logic                sdi;
    logic [bitcount-1:0] rx_data;

    modport master (
        output trigger, data, sdi,
        input  ss, sclk, sdo, busy, complete, rx_data
    );
    modport slave (
        input  trigger, data, sdi,
        output ss, sclk, sdo, busy, complete, rx_data
    );
`else
    modport master (
        output trigger, data,
        input  ss, sclk, sdo, busy, complete
    );
    modport slave (
        input  trigger, data,
        output ss, sclk, sdo, busy, complete
    );
`endif
endinterface

// File: rtl/spi_transmitter.sv
// SPI master serializer, CPHA = 1, SCLK derived from clock by an integer divider.
// Optional full-duplex readback: define SPI_TRANSMITTER_READBACK_EN.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for trigger, ss inactive, sclk idle
// SETUP | ss asserted, D cycles before the first SCLK edge
// LOW   | first half of a bit: sclk low, sdo carries the bit
// HIGH  | second half of a non-final bit: sclk high (receiver samples)
// HOLD  | second half of the final bit: sclk high, ss held, then finish
module spi_transmitter #(
    parameter int bitcount      = 16,
    parameter int ss_polarity   = 0,
    parameter int sclk_polarity = 1,
    parameter int msb_first     = 1,
    parameter int clock_divider = 2
) (
    input  logic              clock,
    input  logic              reset,
    spi_transmitter_if.slave  bus
);
    localparam int bit_w = $clog2(bitcount + 1);
    localparam int div_w = $clog2(clock_divider + 1);
    localparam logic [div_w-1:0] div_load = div_w'(clock_divider - 1);
    localparam logic [bit_w-1:0] bit_load = bit_w'(bitcount - 1);

    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD} state_t;

    state_t              state;
    logic [bitcount-1:0] tx_shift;
    logic [bit_w-1:0]    bit_cnt;
    logic [div_w-1:0]    div_cnt;
    logic                ss_int;
    logic                sclk_int;
    logic                sdo_q;
    logic                busy_q;
    logic                complete_q;

    logic                div_tc;
    logic                next_bit;
    logic [bitcount-1:0] tx_shifted;

    assign div_tc     = (div_cnt == '0);
    assign next_bit   = (msb_first != 0) ? tx_shift[bitcount-1] : tx_shift[0];
    assign tx_shifted = (msb_first != 0) ? {tx_shift[bitcount-2:0], 1'b0}
                                         : {1'b0, tx_shift[bitcount-1:1]};

`ifdef SPI_TRANSMITTER_READBACK_EN
    logic [bitcount-1:0] rx_shift;
    logic [bitcount-1:0] rx_data_q;
    logic [bitcount-1:0] rx_shifted;

    assign rx_shifted = (msb_first != 0) ? {rx_shift[bitcount-2:0], bus.sdi}
                                         : {bus.sdi, rx_shift[bitcount-1:1]};
    assign bus.rx_data = rx_data_q;
`endif

    // Transfer sequencer: phase timing from a down-counting divider, bit count down to the last bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            tx_shift   <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            ss_int     <= 1'b0;
            sclk_int   <= 1'b1;
            sdo_q      <= 1'b0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
`ifdef SPI_TRANSMITTER_READBACK_EN
            rx_shift   <= '0;
            // a reset that aborts a transfer keeps the last received word
            if (!busy_q) rx_data_q <= '0;
`endif
        end else begin
            complete_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.trigger) begin
                        tx_shift <= bus.data;
                        ss_int   <= 1'b1;
                        busy_q   <= 1'b1;
                        div_cnt  <= div_load;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_tc) begin
                        sclk_int <= 1'b0;
                        sdo_q    <= next_bit;
                        tx_shift <= tx_shifted;
                        bit_cnt  <= bit_load;
                        div_cnt  <= div_load;
                        state    <= LOW;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                LOW: begin
                    if (div_tc) begin
                        sclk_int <= 1'b1;
                        div_cnt  <= div_load;
                        state    <= (bit_cnt == '0) ? HOLD : HIGH;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                HIGH: begin
                    if (div_tc) begin
`ifdef SPI_TRANSMITTER_READBACK_EN
                        rx_shift <= rx_shifted;
`endif
                        sclk_int <= 1'b0;
                        sdo_q    <= next_bit;
                        tx_shift <= tx_shifted;
                        bit_cnt  <= bit_cnt - 1'b1;
                        div_cnt  <= div_load;
                        state    <= LOW;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (div_tc) begin
`ifdef SPI_TRANSMITTER_READBACK_EN
                        rx_shift  <= rx_shifted;
                        rx_data_q <= rx_shifted;
`endif
                        ss_int     <= 1'b0;
                        busy_q     <= 1'b0;
                        complete_q <= 1'b1;
                        sdo_q      <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Polarity is a build-time constant, so these are fixed wiring on the registers.
    assign bus.ss       = (ss_polarity   != 0) ? ss_int   : ~ss_int;
    assign bus.sclk     = (sclk_polarity != 0) ? sclk_int : ~sclk_int;
    assign bus.sdo      = sdo_q;
    assign bus.busy     = busy_q;
    assign bus.complete = complete_q;

endmodule
